// File: rtl/seq_pkg.sv
// Shared encodings and defaults for the serial feeder of the 1101 sequence detector.
package seq_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int   DEF_WIDTH    = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry word buffer sitting in front of the shifter; load and unload never coincide.
module ser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             unload,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder: one bit per clock, hold register lets words stream gap-free.
// First bit appears the cycle after acceptance; in_ready drops only while the hold register is full.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_sof,
  output logic             ser_eow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_sof_q, ser_sof_d;
  logic             ser_eow_q, ser_eow_d;
  logic             busy_q, busy_d;

  logic             hold_full, hold_load, hold_unload;
  logic [WIDTH-1:0] hold_data;
  logic             accept, load_pt;

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (hold_load),
    .load_data (in_data),
    .unload    (hold_unload),
    .full      (hold_full),
    .data      (hold_data)
  );

  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;
  assign load_pt  = (state_q == S_IDLE) || (cnt_q == CNT_ONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    if (flush) begin
      cnt_d       = '0;
      state_d     = S_IDLE;
      hold_unload = 1'b1;
    end else if (load_pt && hold_full) begin
      shreg_d     = hold_data;
      hold_unload = 1'b1;
      cnt_d       = CNT_FULL;
      state_d     = S_SHIFT;
    end else if (load_pt && accept) begin
      shreg_d = in_data;
      cnt_d   = CNT_FULL;
      state_d = S_SHIFT;
    end else begin
      hold_load = accept;
      if (state_q == S_SHIFT) begin
        if (cnt_q > CNT_ONE) begin
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
    end

    // Output flops are fed from next-state so they line up with the bit on the wire.
    ser_valid_d = (cnt_d != '0);
    ser_sof_d   = (cnt_d == CNT_FULL);
    ser_eow_d   = (cnt_d == CNT_ONE);
    ser_out_d   = ser_valid_d ? (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]) : IDLE_BIT;
    busy_d      = ser_valid_d || hold_load || (hold_full && !hold_unload);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      ser_sof_q   <= 1'b0;
      ser_eow_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_sof_q   <= ser_sof_d;
      ser_eow_q   <= ser_eow_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_sof   = ser_sof_q;
  assign ser_eow   = ser_eow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: WIDTH=4 MSB/LSB-first instances plus a WIDTH=8 streaming run.
module tb_seq_serializer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a_: WIDTH=4 MSB first, b_: WIDTH=4 LSB first, c_: WIDTH=8 MSB first
  logic [3:0] a_in_data, b_in_data;
  logic [7:0] c_in_data;
  logic a_in_valid, a_in_ready, a_flush, a_ser_out, a_ser_valid, a_ser_sof, a_ser_eow, a_busy;
  logic b_in_valid, b_in_ready, b_flush, b_ser_out, b_ser_valid, b_ser_sof, b_ser_eow, b_busy;
  logic c_in_valid, c_in_ready, c_flush, c_ser_out, c_ser_valid, c_ser_sof, c_ser_eow, c_busy;

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .flush(a_flush), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
    .ser_sof(a_ser_sof), .ser_eow(a_ser_eow), .busy(a_busy));

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(b_flush), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
    .ser_sof(b_ser_sof), .ser_eow(b_ser_eow), .busy(b_busy));

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .flush(c_flush), .ser_out(c_ser_out), .ser_valid(c_ser_valid),
    .ser_sof(c_ser_sof), .ser_eow(c_ser_eow), .busy(c_busy));

  // Observation vector {valid, out, sof, eow, busy, in_ready}
  wire [5:0] a_obs = {a_ser_valid, a_ser_out, a_ser_sof, a_ser_eow, a_busy, a_in_ready};
  wire [5:0] b_obs = {b_ser_valid, b_ser_out, b_ser_sof, b_ser_eow, b_busy, b_in_ready};
  wire [5:0] c_obs = {c_ser_valid, c_ser_out, c_ser_sof, c_ser_eow, c_busy, c_in_ready};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    a_in_data = '0; b_in_data = '0; c_in_data = '0;
    a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
    a_flush = 0; b_flush = 0; c_flush = 0;
    tick; tick;
    total += 3;
    if (a_obs !== 6'b000001) begin bad++; $display("FAIL reset_a: got %b want %b", a_obs, 6'b000001); end
    if (b_obs !== 6'b000001) begin bad++; $display("FAIL reset_b: got %b want %b", b_obs, 6'b000001); end
    if (c_obs !== 6'b000001) begin bad++; $display("FAIL reset_c: got %b want %b", c_obs, 6'b000001); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_idle_accept;
    logic [5:0] exp [0:4] = '{6'b111011, 6'b110011, 6'b100011, 6'b110111, 6'b000001};
    a_in_data = 4'b1101; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (a_obs !== exp[i]) begin bad++; $display("FAIL idle_accept[%0d]: got %b want %b", i, a_obs, exp[i]); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp [0:8] = '{6'b111011, 6'b110010, 6'b100010, 6'b110110,
                              6'b101011, 6'b110011, 6'b110011, 6'b100111, 6'b000001};
    a_in_data = 4'b1101; a_in_valid = 1;
    tick;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (a_obs !== exp[i]) begin bad++; $display("FAIL back_to_back[%0d]: got %b want %b", i, a_obs, exp[i]); end
      if (i == 0) a_in_data = 4'b0110;
      if (i == 1) a_in_valid = 0;
      tick;
    end
  endtask

  task automatic test_lsb_first;
    logic [5:0] exp [0:4] = '{6'b111011, 6'b110011, 6'b100011, 6'b110111, 6'b000001};
    b_in_data = 4'b1011; b_in_valid = 1;
    tick;
    b_in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (b_obs !== exp[i]) begin bad++; $display("FAIL lsb_first[%0d]: got %b want %b", i, b_obs, exp[i]); end
      tick;
    end
  endtask

  task automatic test_async_reset;
    a_in_data = 4'b1101; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    tick;
    total++;
    if (a_obs !== 6'b110011) begin bad++; $display("FAIL areset_pre: got %b want %b", a_obs, 6'b110011); end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (a_obs !== 6'b000001) begin bad++; $display("FAIL areset_async: got %b want %b", a_obs, 6'b000001); end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++;
      if (a_obs !== 6'b000001) begin bad++; $display("FAIL areset_after[%0d]: got %b want %b", i, a_obs, 6'b000001); end
    end
  endtask

  task automatic test_flush;
    a_in_data = 4'b1101; a_in_valid = 1;
    tick;
    a_in_data = 4'b0110;
    tick;
    a_in_valid = 0;
    tick;
    total++;
    if (a_obs !== 6'b100010) begin bad++; $display("FAIL flush_pre: got %b want %b", a_obs, 6'b100010); end
    a_flush = 1;
    tick;
    a_flush = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (a_obs !== 6'b000001) begin bad++; $display("FAIL flush_after[%0d]: got %b want %b", i, a_obs, 6'b000001); end
      tick;
    end
  endtask

  task automatic test_random_stream;
    logic [2:0] q [$];
    logic [2:0] e;
    logic [7:0] w;
    logic       acc;
    int         sent;
    bit         done;
    sent = 0;
    done = 0;
    w = 8'($urandom_range(0, 255));
    c_in_data = w; c_in_valid = 1;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      acc = c_in_valid && c_in_ready;
      tick;
      if (acc) begin
        for (int b = 7; b >= 0; b--) q.push_back({w[b], 1'(b == 7), 1'(b == 0)});
        sent++;
        if (sent < 200) begin
          w = 8'($urandom_range(0, 255));
          c_in_data = w;
        end else begin
          c_in_valid = 0;
        end
      end
      total++;
      if (c_ser_valid) begin
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_extra: got valid=%b want valid=0 at cycle %0d", c_ser_valid, cyc);
        end else begin
          e = q.pop_front();
          if ({c_ser_out, c_ser_sof, c_ser_eow} !== e) begin
            bad++; $display("FAIL stream_bit: got %b want %b at cycle %0d", {c_ser_out, c_ser_sof, c_ser_eow}, e, cyc);
          end
        end
      end else if (q.size() != 0) begin
        bad++; $display("FAIL stream_gap: got valid=0 want valid=1 at cycle %0d", cyc);
      end
      done = (sent == 200) && (q.size() == 0);
    end
    total++;
    if (!done) begin bad++; $display("FAIL stream_timeout: got sent=%0d want sent=200", sent); end
    tick;
    total++;
    if (c_obs !== 6'b000001) begin bad++; $display("FAIL stream_drain: got %b want %b", c_obs, 6'b000001); end
  endtask

  initial begin
    test_reset;
    test_idle_accept;
    test_back_to_back;
    test_lsb_first;
    test_async_reset;
    test_flush;
    test_random_stream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
